cache_control: RTL and testbench

- Sequencing FSM for the 2-way, 8-set, 128-bit-line write-back cache datapath.
- Accepts CPU mem_read/mem_write requests and decides hit/miss from the datapath's ishit_w*/isdirty_w*/lru_out.
- Drives every datapath load/select strobe and runs the pmem handshake for victim writeback and line allocate.
- Sits between the CPU memory port, cache_datapath and physical memory.

---
 rtl/cache_control_pkg.sv | 22 ++
 rtl/cache_control_perf_counter.sv | 22 ++
 rtl/cache_control.sv | 163 ++++++++++++++++
 tb/tb_cache_control.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_control_pkg.sv
// Shared types and select encodings for the cache sequencing FSM and its helpers.
package cache_ctrl_types;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    WRITEBACK,
    ALLOCATE
  } cache_state_t;

  localparam logic [1:0] PADDR_SEL_W1  = 2'b00;
  localparam logic [1:0] PADDR_SEL_W2  = 2'b01;
  localparam logic [1:0] PADDR_SEL_CPU = 2'b10;

  localparam logic DIN_SEL_PMEM = 1'b0;
  localparam logic DIN_SEL_WAY  = 1'b1;

  function automatic logic [1:0] victim_paddr_sel(input logic way);
    return way ? PADDR_SEL_W2 : PADDR_SEL_W1;
  endfunction

endpackage

// File: rtl/cache_control_perf_counter.sv
// Saturating event counter; holds at all-ones once full.
module cache_perf_counter #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cache_control.sv
// Sequencing FSM for the 2-way write-back cache datapath and its pmem handshake.
// Optional performance counters are built when CACHE_PERF_CNT_EN is defined.
module cache_control
  import cache_ctrl_types::*;
#(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mem_read,
  input  logic       mem_write,
  output logic       mem_resp,
  output logic       pmem_read,
  output logic       pmem_write,
  input  logic       pmem_resp,
  input  logic       ishit_w1,
  input  logic       ishit_w2,
  input  logic       isdirty_w1,
  input  logic       isdirty_w2,
  input  logic       lru_out,
  output logic       load_valid_w1,
  output logic       load_tag_w1,
  output logic       load_datastore_w1,
  output logic       load_dirty_w1,
  output logic       load_valid_w2,
  output logic       load_tag_w2,
  output logic       load_datastore_w2,
  output logic       load_dirty_w2,
  output logic       dirty_wdata,
  output logic       load_lru,
  output logic       datastore_in_mux_sel,
  output logic [1:0] pmem_address_mux_sel
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count
`endif
);

  cache_state_t state, next_state;
  logic victim;
  logic missed;

  logic req, is_write, is_hit, hit_way, victim_dirty;

  // A simultaneous read+write is handled as a write.
  assign req          = mem_read | mem_write;
  assign is_write     = mem_write;
  assign is_hit       = ishit_w1 | ishit_w2;
  assign hit_way      = ishit_w2;
  assign victim_dirty = lru_out ? isdirty_w2 : isdirty_w1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      victim <= 1'b0;
      missed <= 1'b0;
    end else begin
      state <= next_state;
      if (state == CHECK && req && !is_hit) begin
        victim <= lru_out;
        missed <= 1'b1;
      end else if (state == IDLE) begin
        missed <= 1'b0;
      end
    end
  end

  always_comb begin
    next_state           = state;
    mem_resp             = 1'b0;
    pmem_read            = 1'b0;
    pmem_write           = 1'b0;
    load_valid_w1        = 1'b0;
    load_tag_w1          = 1'b0;
    load_datastore_w1    = 1'b0;
    load_dirty_w1        = 1'b0;
    load_valid_w2        = 1'b0;
    load_tag_w2          = 1'b0;
    load_datastore_w2    = 1'b0;
    load_dirty_w2        = 1'b0;
    dirty_wdata          = 1'b0;
    load_lru             = 1'b0;
    datastore_in_mux_sel = DIN_SEL_PMEM;
    pmem_address_mux_sel = PADDR_SEL_CPU;

    case (state)
      IDLE: begin
        if (req) next_state = CHECK;
      end

      CHECK: begin
        if (!req) begin
          next_state = IDLE;
        end else if (is_hit) begin
          mem_resp   = 1'b1;
          load_lru   = (lru_out == hit_way);
          next_state = IDLE;
          if (is_write) begin
            dirty_wdata          = 1'b1;
            datastore_in_mux_sel = DIN_SEL_WAY;
            if (hit_way) begin
              load_datastore_w2 = 1'b1;
              load_dirty_w2     = 1'b1;
            end else begin
              load_datastore_w1 = 1'b1;
              load_dirty_w1     = 1'b1;
            end
          end
        end else begin
          next_state = victim_dirty ? WRITEBACK : ALLOCATE;
        end
      end

      WRITEBACK: begin
        pmem_write           = 1'b1;
        pmem_address_mux_sel = victim_paddr_sel(victim);
        if (pmem_resp) next_state = ALLOCATE;
      end

      ALLOCATE: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          next_state = CHECK;
          if (victim) begin
            load_valid_w2     = 1'b1;
            load_tag_w2       = 1'b1;
            load_datastore_w2 = 1'b1;
            load_dirty_w2     = 1'b1;
          end else begin
            load_valid_w1     = 1'b1;
            load_tag_w1       = 1'b1;
            load_datastore_w1 = 1'b1;
            load_dirty_w1     = 1'b1;
          end
        end
      end

      default: next_state = IDLE;
    endcase
  end

`ifdef CACHE_PERF_CNT_EN
  logic hit_inc, miss_inc, wb_inc;

  // Hits that follow a fill belong to a miss already counted.
  assign hit_inc  = (state == CHECK) && req && is_hit && !missed;
  assign miss_inc = (state == CHECK) && req && !is_hit;
  assign wb_inc   = (state == WRITEBACK) && pmem_resp;

  cache_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk(clk), .rst_n(rst_n), .clear(1'b0), .inc(hit_inc), .count(hit_count)
  );
  cache_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk(clk), .rst_n(rst_n), .clear(1'b0), .inc(miss_inc), .count(miss_count)
  );
  cache_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_wb_cnt (
    .clk(clk), .rst_n(rst_n), .clear(1'b0), .inc(wb_inc), .count(wb_count)
  );
`endif

endmodule

// File: tb/tb_cache_control.sv
// Bench for cache_control: a tag/valid/dirty/LRU cache model plays the datapath
// and predicts every strobe per cycle; counters are checked when CACHE_PERF_CNT_EN is set.
module tb_cache_control;

  localparam int unsigned TB_CNT_W = 2;
  localparam int CNT_MAX = (1 << TB_CNT_W) - 1;
  localparam logic [15:0] IDLE_V = 16'h0002;

  logic clk = 1'b0;
  logic rst_n;
  logic mem_read, mem_write, mem_resp;
  logic pmem_read, pmem_write, pmem_resp;
  logic ishit_w1, ishit_w2, isdirty_w1, isdirty_w2, lru_out;
  logic load_valid_w1, load_tag_w1, load_datastore_w1, load_dirty_w1;
  logic load_valid_w2, load_tag_w2, load_datastore_w2, load_dirty_w2;
  logic dirty_wdata, load_lru, datastore_in_mux_sel;
  logic [1:0] pmem_address_mux_sel;
`ifdef CACHE_PERF_CNT_EN
  logic [TB_CNT_W-1:0] hit_count, miss_count, wb_count;
`endif

  always #5 clk = ~clk;

  cache_control #(.CNT_WIDTH(TB_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
    .ishit_w1(ishit_w1), .ishit_w2(ishit_w2),
    .isdirty_w1(isdirty_w1), .isdirty_w2(isdirty_w2), .lru_out(lru_out),
    .load_valid_w1(load_valid_w1), .load_tag_w1(load_tag_w1),
    .load_datastore_w1(load_datastore_w1), .load_dirty_w1(load_dirty_w1),
    .load_valid_w2(load_valid_w2), .load_tag_w2(load_tag_w2),
    .load_datastore_w2(load_datastore_w2), .load_dirty_w2(load_dirty_w2),
    .dirty_wdata(dirty_wdata), .load_lru(load_lru),
    .datastore_in_mux_sel(datastore_in_mux_sel),
    .pmem_address_mux_sel(pmem_address_mux_sel)
`ifdef CACHE_PERF_CNT_EN
    ,
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
  );

  logic [15:0] obs;
  assign obs = {mem_resp, pmem_read, pmem_write,
                load_valid_w1, load_tag_w1, load_datastore_w1, load_dirty_w1,
                load_valid_w2, load_tag_w2, load_datastore_w2, load_dirty_w2,
                dirty_wdata, load_lru, datastore_in_mux_sel, pmem_address_mux_sel};

  // Reference cache contents, indexed [set][way], way 0 = way1.
  logic m_valid [8][2];
  logic m_dirty [8][2];
  int   m_tag   [8][2];
  int   m_lru   [8];
  int   hits_m, misses_m, wbs_m;
  int   n_chk, n_pass, n_fail;

  function automatic logic [15:0] ev(input logic resp, input logic pr, input logic pw,
                                     input logic [3:0] s1, input logic [3:0] s2,
                                     input logic dw, input logic ll, input logic din,
                                     input logic [1:0] sel);
    return {resp, pr, pw, s1, s2, dw, ll, din, sel};
  endfunction

  function automatic logic [15:0] hit_exp(input int w, input logic wr, input int lru_now);
    logic [3:0] s1, s2;
    s1 = '0;
    s2 = '0;
    if (wr) begin
      if (w == 0) s1 = 4'b0011;
      else        s2 = 4'b0011;
    end
    return ev(1'b1, 1'b0, 1'b0, s1, s2, wr, lru_now == w, wr, 2'b10);
  endfunction

  function automatic logic [15:0] fill_exp(input int v);
    return ev(1'b0, 1'b1, 1'b0, (v == 0) ? 4'hF : 4'h0, (v == 1) ? 4'hF : 4'h0,
              1'b0, 1'b0, 1'b0, 2'b10);
  endfunction

  function automatic int sat(input int x);
    return (x >= CNT_MAX) ? CNT_MAX : x + 1;
  endfunction

  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    n_chk++;
    assert (o === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic check_counts(input string tag);
`ifdef CACHE_PERF_CNT_EN
    chk({tag, "_hit_count"},  16'(hit_count),  16'(hits_m));
    chk({tag, "_miss_count"}, 16'(miss_count), 16'(misses_m));
    chk({tag, "_wb_count"},   16'(wb_count),   16'(wbs_m));
`else
    n_chk += 0;
`endif
  endtask

  task automatic drive_dp(input int set, input int tg);
    ishit_w1   = m_valid[set][0] && (m_tag[set][0] == tg);
    ishit_w2   = m_valid[set][1] && (m_tag[set][1] == tg);
    isdirty_w1 = m_dirty[set][0];
    isdirty_w2 = m_dirty[set][1];
    lru_out    = (m_lru[set] == 1);
  endtask

  task automatic txn(input logic wr, input logic both, input int set, input int tg,
                     input int d, input logic drop, input logic rst_wb);
    int hw, v;
    logic wrx;
    wrx       = wr | both;
    mem_write = wr | both;
    mem_read  = !wr | both;
    drive_dp(set, tg);
    @(negedge clk) chk("idle_req", obs, IDLE_V);
    @(posedge clk) #1;
    hw = -1;
    for (int w = 0; w < 2; w++)
      if (m_valid[set][w] && m_tag[set][w] == tg) hw = w;
    if (hw >= 0) begin
      @(negedge clk) chk("check_hit", obs, hit_exp(hw, wrx, m_lru[set]));
      m_lru[set] = 1 - hw;
      if (wrx) m_dirty[set][hw] = 1'b1;
      hits_m = sat(hits_m);
    end else begin
      v = m_lru[set];
      @(negedge clk) chk("check_miss", obs, IDLE_V);
      misses_m = sat(misses_m);
      @(posedge clk) #1;
      if (m_valid[set][v] && m_dirty[set][v]) begin
        for (int k = 0; k <= d; k++) begin
          lru_out   = 1'($urandom);
          pmem_resp = (k == d);
          @(negedge clk) chk((k == d) ? "wb_resp" : "wb_wait", obs,
                             ev(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, {1'b0, v[0]}));
          if (rst_wb) begin
            #1 rst_n = 1'b0;
            #1 chk("rst_wb_async", obs, IDLE_V);
            mem_read  = 1'b0;
            mem_write = 1'b0;
            pmem_resp = 1'b0;
            @(posedge clk) #1;
            chk("rst_wb_hold", obs, IDLE_V);
            rst_n    = 1'b1;
            hits_m   = 0;
            misses_m = 0;
            wbs_m    = 0;
            @(negedge clk) chk("rst_wb_idle", obs, IDLE_V);
            check_counts("rst_wb");
            @(posedge clk) #1;
            return;
          end
          @(posedge clk) #1;
        end
        pmem_resp = 1'b0;
        wbs_m = sat(wbs_m);
        m_dirty[set][v] = 1'b0;
      end
      for (int k = 0; k <= d; k++) begin
        lru_out   = 1'($urandom);
        pmem_resp = (k == d);
        if (drop && k == 0) begin
          mem_read  = 1'b0;
          mem_write = 1'b0;
        end
        @(negedge clk) chk((k == d) ? "alloc_fill" : "alloc_wait", obs,
                           (k == d) ? fill_exp(v)
                                    : ev(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 2'b10));
        @(posedge clk) #1;
      end
      pmem_resp = 1'b0;
      m_valid[set][v] = 1'b1;
      m_tag[set][v]   = tg;
      m_dirty[set][v] = 1'b0;
      drive_dp(set, tg);
      if (drop) begin
        @(negedge clk) chk("check_dropped", obs, IDLE_V);
        @(posedge clk) #1;
        @(negedge clk) chk("idle_after_drop", obs, IDLE_V);
        @(posedge clk) #1;
        return;
      end
      @(negedge clk) chk("recheck_hit", obs, hit_exp(v, wrx, m_lru[set]));
      m_lru[set] = 1 - v;
      if (wrx) m_dirty[set][v] = 1'b1;
    end
    @(posedge clk) #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    n_chk = 0; n_pass = 0; n_fail = 0;
    hits_m = 0; misses_m = 0; wbs_m = 0;
    for (int s = 0; s < 8; s++) begin
      m_lru[s] = 0;
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_tag[s][w]   = 0;
      end
    end
    rst_n = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
    ishit_w1 = 1'b0; ishit_w2 = 1'b0; isdirty_w1 = 1'b0; isdirty_w2 = 1'b0; lru_out = 1'b0;
    @(negedge clk) chk("reset", obs, IDLE_V);
    check_counts("reset");
    @(posedge clk) #1 rst_n = 1'b1;

    // Read hit on way2 of set 3 with the victim pointing at way2.
    m_valid[3][1] = 1'b1; m_tag[3][1] = 5; m_lru[3] = 1;
    txn(1'b0, 1'b0, 3, 5, 0, 1'b0, 1'b0);

    // Read miss, clean victim way1, fill after five wait cycles.
    txn(1'b0, 1'b0, 0, 2, 5, 1'b0, 1'b0);

    // Write miss with dirty victim way2.
    m_valid[5][0] = 1'b1; m_tag[5][0] = 2;
    m_valid[5][1] = 1'b1; m_tag[5][1] = 1; m_dirty[5][1] = 1'b1; m_lru[5] = 1;
    txn(1'b1, 1'b0, 5, 3, 3, 1'b0, 1'b0);
    check_counts("after_wb");

    // Reset while writing back.
    m_valid[6][0] = 1'b1; m_tag[6][0] = 1; m_dirty[6][0] = 1'b1; m_lru[6] = 0;
    txn(1'b0, 1'b0, 6, 2, 3, 1'b0, 1'b1);
    txn(1'b0, 1'b0, 6, 2, 1, 1'b0, 1'b0);

    // Stray pmem_resp while idle.
    pmem_resp = 1'b1;
    @(negedge clk) chk("spurious_resp", obs, IDLE_V);
    @(posedge clk) #1 pmem_resp = 1'b0;
    @(negedge clk) chk("idle_after_spurious", obs, IDLE_V);
    @(posedge clk) #1;

    // Request withdrawn during allocate.
    txn(1'b0, 1'b0, 7, 1, 2, 1'b1, 1'b0);

    // Repeated hits drive the hit counter into saturation.
    for (int i = 0; i < 5; i++) txn(1'b0, 1'b0, 3, 5, 0, 1'b0, 1'b0);
    check_counts("hits_sat");

    for (int i = 0; i < 40; i++) begin
      txn(1'($urandom), ($urandom_range(0, 7) == 0), $urandom_range(0, 7),
          $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'b0);
    end
    check_counts("final");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
